// File: rtl/inst_sram_responder.sv
// Instruction-SRAM fetch responder: boot-ROM window decode, word array, wait states, stall.
// Optional INST_SRAM_FWD_EN forwards a same-edge load to the word being read.
module inst_sram_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hbfc00000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_sram_en,
  input  logic [31:0]           inst_sram_addr,
  output logic [31:0]           inst_sram_rdata,
  output logic                  inst_sram_valid,
  output logic                  addr_err,
  output logic                  stall,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [31:0] WINDOW    = 32'(4) << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, addr_next;
  logic        valid_next, stall_next, enter_resp;

  logic [31:0]           rd_addr, rd_off;
  logic                  rd_ok;
  logic [DEPTH_LOG2-1:0] rd_idx;

  // State register, also registering the next-state-derived valid and stall
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      addr_reg        <= 32'd0;
      inst_sram_valid <= 1'b0;
      stall           <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      addr_reg        <= addr_next;
      inst_sram_valid <= valid_next;
      stall           <= stall_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (inst_sram_en) begin
          addr_next = inst_sram_addr;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_INIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the read happens on the accept edge, so decode the live address
  always_comb begin
    enter_resp = (state_next == RESP);
    valid_next = enter_resp;
    stall_next = (state_next == WAIT);
    rd_addr    = (state_reg == WAIT) ? addr_reg : inst_sram_addr;
    rd_off     = rd_addr - BASE_ADDR;
    rd_ok      = (rd_off < WINDOW) && (rd_addr[1:0] == 2'b00);
    rd_idx     = rd_off[DEPTH_LOG2+1:2];
  end

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_sram_rdata <= 32'd0;
      addr_err        <= 1'b0;
    end else if (enter_resp) begin
      if (rd_ok) begin
        addr_err <= 1'b0;
`ifdef INST_SRAM_FWD_EN
        if (load_en && (load_addr == rd_idx)) inst_sram_rdata <= load_data;
        else                                  inst_sram_rdata <= mem[rd_idx];
`else
        inst_sram_rdata <= mem[rd_idx];
`endif
      end else begin
        addr_err        <= 1'b1;
        inst_sram_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: one zero-wait and one three-wait instance checked
// against a plain array model of the boot-ROM window.
module tb_inst_sram_responder;

  localparam logic [31:0] BASE = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic        en0, valid0, err0, stall0;
  logic [31:0] addr0, rdata0;
  logic        en3, valid3, err3, stall3;
  logic [31:0] addr3, rdata3;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [1024];

  always #5 clk = ~clk;

  inst_sram_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(en0), .inst_sram_addr(addr0), .inst_sram_rdata(rdata0),
    .inst_sram_valid(valid0), .addr_err(err0), .stall(stall0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  inst_sram_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(en3), .inst_sram_addr(addr3), .inst_sram_rdata(rdata3),
    .inst_sram_valid(valid3), .addr_err(err3), .stall(stall3),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // Expected {addr_err, rdata} for a fetch: 4 KB window from BASE, word aligned
  function automatic logic [32:0] ref_fetch(input logic [31:0] a);
    longint unsigned ua;
    ua = longint'(a);
    if (ua >= longint'(BASE) && ua < longint'(BASE) + 4096 && (ua % 4) == 0)
      return {1'b0, ref_mem[int'((ua - longint'(BASE)) / 4)]};
    return {1'b1, 32'h0};
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + 32'(4 * $urandom_range(0, 1023));
      3:       return BASE + 32'd4096;
      4:       return BASE + 32'(4 * $urandom_range(0, 1023) + $urandom_range(1, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] d);
    load_en = 1'b1; load_addr = 10'(idx); load_data = d;
    tick();
    load_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({valid0, stall0, err0, rdata0} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_dut0: got v=%b s=%b e=%b d=%h, want all 0", valid0, stall0, err0, rdata0);
    end
    n_cmp++;
    if ({valid3, stall3, err3, rdata3} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_dut3: got v=%b s=%b e=%b d=%h, want all 0", valid3, stall3, err3, rdata3);
    end
    resetn = 1'b1;
    tick();
  endtask

  // Zero-wait instance: one fetch per cycle, checked one edge after it is presented
  task automatic fetch_seq0(input string name, input logic [31:0] addrs [$]);
    logic [32:0] exp;
    foreach (addrs[i]) begin
      en0 = 1'b1; addr0 = addrs[i];
      exp = ref_fetch(addrs[i]);
      tick();
      n_cmp++;
      if ({valid0, stall0, err0, rdata0} !== {1'b1, 1'b0, exp}) begin
        n_err++;
        $display("FAIL %s: addr=%h got v=%b s=%b e=%b d=%h, want v=1 s=0 e=%b d=%h",
                 name, addrs[i], valid0, stall0, err0, rdata0, exp[32], exp[31:0]);
      end else begin
        $display("fetch0 %s addr=%h e=%b d=%h", name, addrs[i], err0, rdata0);
      end
    end
    en0 = 1'b0;
    tick();
    n_cmp++;
    if ({valid0, stall0, err0, rdata0} !== {1'b0, 1'b0, exp}) begin
      n_err++;
      $display("FAIL %s_idle_hold: got v=%b s=%b e=%b d=%h, want v=0 s=0 e=%b d=%h",
               name, valid0, stall0, err0, rdata0, exp[32], exp[31:0]);
    end
  endtask

  // Three-wait instance: stall for 3 cycles with noise on en/addr, then one valid, then idle
  task automatic wait_fetch(input string name, input logic [31:0] a);
    logic [32:0] exp;
    exp = ref_fetch(a);
    en3 = 1'b1; addr3 = a;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({valid3, stall3} !== 2'b01) begin
        n_err++;
        $display("FAIL %s_wait%0d: got v=%b s=%b, want v=0 s=1", name, c, valid3, stall3);
      end
      en3 = 1'($urandom); addr3 = $urandom;
      tick();
    end
    n_cmp++;
    if ({valid3, stall3, err3, rdata3} !== {1'b1, 1'b0, exp}) begin
      n_err++;
      $display("FAIL %s_resp: addr=%h got v=%b s=%b e=%b d=%h, want v=1 s=0 e=%b d=%h",
               name, a, valid3, stall3, err3, rdata3, exp[32], exp[31:0]);
    end else begin
      $display("fetch3 %s addr=%h e=%b d=%h", name, a, err3, rdata3);
    end
    en3 = 1'b0;
    tick();
    n_cmp++;
    if ({valid3, stall3, err3, rdata3} !== {1'b0, 1'b0, exp}) begin
      n_err++;
      $display("FAIL %s_idle_hold: got v=%b s=%b e=%b d=%h, want v=0 s=0 e=%b d=%h",
               name, valid3, stall3, err3, rdata3, exp[32], exp[31:0]);
    end
  endtask

  task automatic test_basic();
    logic [31:0] q [$];
    load_word(0, 32'h3c1d0000);
    load_word(1, 32'h27bd0010);
    q = '{32'hbfc00000, 32'hbfc00004};
    fetch_seq0("basic", q);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    for (int i = 0; i < 40; i++) q.push_back(rand_addr());
    fetch_seq0("b2b", q);
  endtask

  task automatic test_bad_addr();
    logic [31:0] q [$];
    q = '{32'hbfc01000, 32'hbfc00002, 32'h00000000, 32'hbfc00ffc};
    fetch_seq0("bad", q);
    wait_fetch("bad3_oor", 32'hbfc01000);
    wait_fetch("bad3_mis", 32'hbfc00002);
  endtask

  task automatic test_wait();
    wait_fetch("wait_plan", 32'hbfc00004);
    for (int i = 0; i < 10; i++) wait_fetch("wait_rand", rand_addr());
  endtask

  task automatic test_fwd();
    logic [31:0] want;
    load_word(5, 32'h0);
    load_en = 1'b1; load_addr = 10'd5; load_data = 32'hdeadbeef;
    en0 = 1'b1; addr0 = 32'hbfc00014;
`ifdef INST_SRAM_FWD_EN
    want = 32'hdeadbeef;
`else
    want = 32'h0;
`endif
    tick();
    load_en = 1'b0;
    ref_mem[5] = 32'hdeadbeef;
    n_cmp++;
    if ({valid0, err0, rdata0} !== {1'b1, 1'b0, want}) begin
      n_err++;
      $display("FAIL fwd_same_edge: got v=%b e=%b d=%h, want v=1 e=0 d=%h", valid0, err0, rdata0, want);
    end
    tick();
    en0 = 1'b0;
    n_cmp++;
    if ({valid0, err0, rdata0} !== {1'b1, 1'b0, 32'hdeadbeef}) begin
      n_err++;
      $display("FAIL fwd_repeat: got v=%b e=%b d=%h, want v=1 e=0 d=deadbeef", valid0, err0, rdata0);
    end
    tick();
  endtask

  task automatic test_reset_wait();
    logic [31:0] d7;
    d7 = $urandom | 32'h1;
    load_word(9, 32'h13572468);
    wait_fetch("pre_rst", 32'hbfc00004);
    en3 = 1'b1; addr3 = BASE + 32'd36;
    tick();
    en3 = 1'b0;
    tick();
    resetn = 1'b0;
    load_en = 1'b1; load_addr = 10'd7; load_data = d7;
    tick();
    resetn = 1'b1;
    load_en = 1'b0;
    ref_mem[7] = d7;
    n_cmp++;
    if ({valid3, stall3, err3, rdata3} !== 35'd0) begin
      n_err++;
      $display("FAIL rst_in_wait: got v=%b s=%b e=%b d=%h, want all 0", valid3, stall3, err3, rdata3);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({valid3, stall3} !== 2'b00) begin
        n_err++;
        $display("FAIL rst_no_late_valid%0d: got v=%b s=%b, want v=0 s=0", c, valid3, stall3);
      end
    end
    wait_fetch("post_rst9", BASE + 32'd36);
    wait_fetch("post_rst7", BASE + 32'd28);
    wait_fetch("post_rst1", BASE + 32'd4);
  endtask

  initial begin
    resetn = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    en0 = 1'b0; addr0 = '0; en3 = 1'b0; addr3 = '0;
    test_reset();
    for (int i = 0; i < 1024; i++) load_word(i, $urandom);
    test_basic();
    test_back_to_back();
    test_bad_addr();
    test_wait();
    test_fwd();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_sram_responder.md
Name: inst_sram_responder

Overview:
Responder end of the instruction-SRAM fetch interface. It accepts the fetch unit's enable/address each cycle, decodes the address against a boot-ROM window and reads a word-addressed array. It returns the instruction word with configurable wait-state latency and drives a stall back to the PC generator while a fetch is outstanding. A side load port preloads or patches the array.

Parameters:
DEPTH_LOG2, 10, log2 of array depth in 32-bit words (default 1024 words = 4 KB)
BASE_ADDR, 32'hbfc00000, byte address mapped to array word 0
WAIT_CYCLES, 0, extra wait states per fetch (0..15)

Ports:
clk  input  1  clock, all state updates on posedge
resetn  input  1  synchronous active-low reset
inst_sram_en  input  1  fetch request strobe
inst_sram_addr  input  32  fetch byte address
inst_sram_rdata  output  32  returned instruction word
inst_sram_valid  output  1  rdata/addr_err valid this cycle (one-cycle pulse per fetch)
addr_err  output  1  fetch was out of window or misaligned; qualified by valid
stall  output  1  fetch outstanding; PC generator must hold its address
load_en  input  1  array write strobe
load_addr  input  DEPTH_LOG2  word index to write
load_data  input  32  word to write

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, wait counter=0, inst_sram_rdata=0, inst_sram_valid=0, addr_err=0, stall=0. Array contents are not cleared. Reset during WAIT abandons the request; no valid is produced.
- States: IDLE, WAIT, RESP.
- Accept: request accepted at a posedge when state is IDLE or RESP and inst_sram_en=1. The address is latched at acceptance.
- WAIT_CYCLES=0: accept -> RESP next cycle with valid=1. Back-to-back accepts give one valid per cycle; throughput is 1 fetch/cycle.
- WAIT_CYCLES=N>0: accept -> WAIT with counter=N-1. stall=1 for every cycle in WAIT. Counter decrements each cycle; at counter=0 -> RESP. Valid appears N+1 cycles after the accept edge.
- While in WAIT: inst_sram_en and inst_sram_addr are ignored.
- RESP: valid=1 for exactly one cycle. With a new accept the next state is WAIT or RESP; with en=0 the next state is IDLE and valid=0.
- rdata/addr_err hold their last values when valid=0.
- Decode: off = addr - BASE_ADDR (32-bit modular arithmetic). In range iff off < 4<<DEPTH_LOG2 and addr[1:0]==0. Index = off[DEPTH_LOG2+1:2].
- Out of range or misaligned: rdata=0, addr_err=1, array not read. Otherwise addr_err=0 and rdata = array[index].
- Read timing: the array is read at the posedge that enters RESP, using the latched index.
- Load: load_en=1 writes array[load_addr] at the posedge. Allowed in any state, including during reset.
- Same-edge load and read to the same index: see Optional Feature.
- stall is registered and derived from next state. It is 0 in IDLE and RESP.

Optional Feature:
INST_SRAM_FWD_EN
- Defined: if load_en=1 and load_addr equals the index being read at the same edge (in-range fetch), rdata = load_data (write-through forwarding).
- Undefined: rdata returns the array's pre-write contents. The write still completes, and later reads see the new value.

Test Plan:
- Reset then WAIT_CYCLES=0; load word0=32'h3c1d0000, word1=32'h27bd0010; en=1 with addr bfc00000 then bfc00004 on consecutive cycles -> valid on two consecutive cycles, rdata 3c1d0000 then 27bd0010, addr_err=0, stall never 1.
- WAIT_CYCLES=3; fetch bfc00004 -> stall=1 for 3 cycles, then valid=1 with rdata 27bd0010 on the 4th cycle after accept; address changes during WAIT are ignored.
- Fetch 32'hbfc01000 (first beyond 4 KB), 32'hbfc00002 (misaligned) and 32'h00000000 -> each gives valid=1, addr_err=1, rdata=0.
- Same edge: load_en=1, load_addr=5, load_data=32'hdeadbeef, fetch bfc00014 (old word 0) -> rdata=deadbeef with INST_SRAM_FWD_EN, 0 without; a repeat fetch returns deadbeef in both builds.
- WAIT_CYCLES=3; assert resetn=0 during the 2nd WAIT cycle -> next cycle valid=0, stall=0, rdata=0, state IDLE; previously loaded words still read back correctly after reset.
- en=0 after RESP -> valid drops to 0 the next cycle, rdata holds its last value, stall=0.
